sram_dp_param: RTL and testbench

//  Parametrised true dual-port synchronous RAM: two independent read/write ports, byte-lane write enables,

---
 rtl/sram_dp_pkg.sv | 16 +
 rtl/sram_dp_lane.sv | 92 +++++++++
 rtl/sram_dp_param.sv | 136 +++++++++++++
 tb/tb_sram_dp_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_pkg.sv
// Shared types, constants and helpers for the parametrised dual-port SRAM.
package sram_dp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_WRITE_FIRST = 32'sd0;
    localparam int RDW_READ_FIRST  = 32'sd1;

    function automatic int nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/sram_dp_lane.sv
// One byte-lane column of the dual-port array: storage, write-write collision
// resolution and per-port read-during-write muxing for this lane only.
module sram_dp_lane
    import sram_dp_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int COLL_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              acc_a,
    input  logic              wp_a,
    input  logic              wl_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [BYTE_W-1:0] din_a,
    output logic [BYTE_W-1:0] q_a,
    input  logic              acc_b,
    input  logic              wp_b,
    input  logic              wl_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [BYTE_W-1:0] din_b,
    output logic [BYTE_W-1:0] q_b
);

    localparam int   DEPTH       = 2 ** ADDR_W;
    localparam logic B_WINS      = (COLL_PRI == 32'sd1);
    localparam logic WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    logic [BYTE_W-1:0] mem_r [DEPTH];
    logic [BYTE_W-1:0] old_a_s, old_b_s, fin_a_s, fin_b_s, rd_a_s, rd_b_s;
    logic              same_s;

    // Final stored value at each port's address after collision resolution.
    always_comb begin
        same_s  = (addr_a == addr_b);
        old_a_s = mem_r[addr_a];
        old_b_s = mem_r[addr_b];
        fin_a_s = old_a_s;
        fin_b_s = old_b_s;
        if (wl_b && same_s && (!wl_a || B_WINS)) begin
            fin_a_s = din_b;
        end else if (wl_a) begin
            fin_a_s = din_a;
        end else begin
            fin_a_s = old_a_s;
        end
        if (wl_a && same_s && (!wl_b || !B_WINS)) begin
            fin_b_s = din_a;
        end else if (wl_b) begin
            fin_b_s = din_b;
        end else begin
            fin_b_s = old_b_s;
        end
        // A writing port sees the resolved word in write-first mode; readers always see the old word.
        rd_a_s = (wp_a && WRITE_FIRST) ? fin_a_s : old_a_s;
        rd_b_s = (wp_b && WRITE_FIRST) ? fin_b_s : old_b_s;
    end

    // Array storage; not reset, the clear FSM zeroes it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_r[clr_addr] <= '0;
        end else begin
            if (wl_a) begin
                mem_r[addr_a] <= fin_a_s;
            end
            if (wl_b) begin
                mem_r[addr_b] <= fin_b_s;
            end
        end
    end

    // Per-port read data registers, updated only on an accepted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (acc_a) begin
                q_a <= rd_a_s;
            end
            if (acc_b) begin
                q_b <= rd_b_s;
            end
        end
    end

endmodule

// File: rtl/sram_dp_param.sv
// True dual-port synchronous RAM with byte-lane writes and a self-clearing FSM.
// Define SRAM_DP_OUT_REG_EN to add an output register stage (2-cycle read latency).
module sram_dp_param
    import sram_dp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int COLL_PRI = 0,
    localparam int NB      = nb(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [NB-1:0]     be_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [NB-1:0]     be_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_t        state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              busy_r;
    logic              clr_en_s, acc_a_s, acc_b_s, wp_a_s, wp_b_s;
    logic [NB-1:0]     wl_a_s, wl_b_s;
    logic [DATA_W-1:0] raw_q_a_s, raw_q_b_s;

    // Clear FSM: sweeps every address once after reset or on clr_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= '0;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= '0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        clr_addr_r <= clr_addr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign clr_en_s = (state_r == ST_CLEAR);
    assign acc_a_s  = en_a & ~busy_r;
    assign acc_b_s  = en_b & ~busy_r;
    assign wp_a_s   = acc_a_s & we_a;
    assign wp_b_s   = acc_b_s & we_b;
    assign wl_a_s   = {NB{wp_a_s}} & be_a;
    assign wl_b_s   = {NB{wp_b_s}} & be_b;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        sram_dp_lane #(
            .ADDR_W  (ADDR_W),
            .BYTE_W  (BYTE_W),
            .RDW_MODE(RDW_MODE),
            .COLL_PRI(COLL_PRI)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_en  (clr_en_s),
            .clr_addr(clr_addr_r),
            .acc_a   (acc_a_s),
            .wp_a    (wp_a_s),
            .wl_a    (wl_a_s[i]),
            .addr_a  (addr_a),
            .din_a   (data_a[i*BYTE_W +: BYTE_W]),
            .q_a     (raw_q_a_s[i*BYTE_W +: BYTE_W]),
            .acc_b   (acc_b_s),
            .wp_b    (wp_b_s),
            .wl_b    (wl_b_s[i]),
            .addr_b  (addr_b),
            .din_b   (data_b[i*BYTE_W +: BYTE_W]),
            .q_b     (raw_q_b_s[i*BYTE_W +: BYTE_W])
        );
    end

`ifdef SRAM_DP_OUT_REG_EN
    logic              acc_a_d_r, acc_b_d_r;
    logic [DATA_W-1:0] out_a_r, out_b_r;

    // Output stage advances only after a cycle in which the port was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a_d_r <= 1'b0;
            acc_b_d_r <= 1'b0;
            out_a_r   <= '0;
            out_b_r   <= '0;
        end else begin
            acc_a_d_r <= acc_a_s;
            acc_b_d_r <= acc_b_s;
            if (acc_a_d_r) begin
                out_a_r <= raw_q_a_s;
            end
            if (acc_b_d_r) begin
                out_b_r <= raw_q_b_s;
            end
        end
    end

    assign q_a = out_a_r;
    assign q_b = out_b_r;
`else
    assign q_a = raw_q_a_s;
    assign q_b = raw_q_b_s;
`endif

endmodule

// File: tb/tb_sram_dp_param.sv
// Randomised + directed bench for sram_dp_param; two instances cover both RDW/COLL settings.
module tb_sram_dp_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int BYTE_W = 8;
    localparam int NB     = DATA_W / BYTE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clr_req;
    logic              en_a, we_a, en_b, we_b;
    logic [NB-1:0]     be_a, be_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic [DATA_W-1:0] q_a0, q_b0, q_a1, q_b1;
    logic              busy0, busy1;

    sram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .RDW_MODE(0), .COLL_PRI(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b0));

    sram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .RDW_MODE(1), .COLL_PRI(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1));

    // Reference model: config 0 = write-first / A wins, config 1 = read-first / B wins.
    logic [DATA_W-1:0] m_mem [2][DEPTH];
    logic [DATA_W-1:0] m_q   [2][2];
    logic [DATA_W-1:0] m_out [2][2];
    logic              m_acc_d [2];
    logic              m_busy;
    int                m_cnt;
    int                checks = 0;
    int                errors = 0;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0] be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] exp_q(input int c, input int p);
`ifdef SRAM_DP_OUT_REG_EN
        return m_out[c][p];
`else
        return m_q[c][p];
`endif
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("q_a cfg0", q_a0, exp_q(0, 0));
        chk("q_b cfg0", q_b0, exp_q(0, 1));
        chk("q_a cfg1", q_a1, exp_q(1, 0));
        chk("q_b cfg1", q_b1, exp_q(1, 1));
        chk("busy cfg0", DATA_W'(busy0), DATA_W'(m_busy));
        chk("busy cfg1", DATA_W'(busy1), DATA_W'(m_busy));
    endtask

    // Apply one clock edge of the specification's rules to the model.
    task automatic model_edge();
        logic [DATA_W-1:0] old_a, old_b;
        logic acc_a, acc_b;
        acc_a = en_a && !m_busy;
        acc_b = en_b && !m_busy;
        for (int c = 0; c < 2; c++) begin
            if (m_acc_d[0]) m_out[c][0] = m_q[c][0];
            if (m_acc_d[1]) m_out[c][1] = m_q[c][1];
            if (m_busy) begin
                m_mem[c][m_cnt] = '0;
            end else begin
                old_a = m_mem[c][addr_a];
                old_b = m_mem[c][addr_b];
                // The winning port writes last so its lanes overwrite the loser's.
                for (int k = 0; k < 2; k++) begin
                    int p;
                    p = (c == 0) ? 1 - k : k;
                    if (p == 0 && acc_a && we_a) m_mem[c][addr_a] = merge(m_mem[c][addr_a], data_a, be_a);
                    if (p == 1 && acc_b && we_b) m_mem[c][addr_b] = merge(m_mem[c][addr_b], data_b, be_b);
                end
                if (acc_a) m_q[c][0] = (we_a && c == 0) ? m_mem[c][addr_a] : old_a;
                if (acc_b) m_q[c][1] = (we_b && c == 0) ? m_mem[c][addr_b] : old_b;
            end
        end
        m_acc_d[0] = acc_a;
        m_acc_d[1] = acc_b;
        if (m_busy) begin
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            else m_cnt++;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_busy = 1'b1;
        m_cnt  = 0;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                m_q[c][p]   = '0;
                m_out[c][p] = '0;
            end
        end
        m_acc_d[0] = 1'b0;
        m_acc_d[1] = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; clr_req = 1'b0;
    endtask

    task automatic set_a(input logic we, input logic [NB-1:0] be, input int addr, input logic [DATA_W-1:0] d);
        en_a = 1'b1; we_a = we; be_a = be; addr_a = ADDR_W'(addr); data_a = d;
    endtask

    task automatic set_b(input logic we, input logic [NB-1:0] be, input int addr, input logic [DATA_W-1:0] d);
        en_b = 1'b1; we_b = we; be_b = be; addr_b = ADDR_W'(addr); data_b = d;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            set_a(1'b0, 4'hF, i, 32'h0);
            set_b(1'b0, 4'hF, DEPTH - 1 - i, 32'h0);
            step();
        end
        idle();
        step();
    endtask

    task automatic wait_clear_done();
        int guard;
        guard = 0;
        idle();
        while (m_busy && guard < 200) begin
            step();
            guard++;
        end
        chk("clear_done busy0", DATA_W'(busy0), 32'h0);
    endtask

    task automatic rand_inputs(input int max_addr);
        en_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
        en_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
        be_a = NB'($urandom_range(0, 15)); be_b = NB'($urandom_range(0, 15));
        addr_a = ADDR_W'($urandom_range(0, max_addr)); addr_b = ADDR_W'($urandom_range(0, max_addr));
        data_a = $urandom; data_b = $urandom;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        be_a = '0; be_b = '0; addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < DEPTH; i++) m_mem[c][i] = 32'hDEAD_BEEF;
        end
        #2;
        do_reset();

        // Power-up clear: busy for DEPTH cycles, then everything reads zero.
        for (int i = 0; i < DEPTH; i++) step();
        chk("busy after clear", DATA_W'(busy0), 32'h0);
        read_all();

        // Port A write, port B read next cycle.
        idle(); set_a(1'b1, 4'hF, 5, 32'hA5); step();
        idle(); set_b(1'b0, 4'hF, 5, 32'h0); step();
        idle(); step();
        chk("xport_read", q_b0, 32'hA5);

        // Byte-lane merge.
        idle(); set_a(1'b1, 4'hF, 7, 32'h11223344); step();
        idle(); set_a(1'b1, 4'b0101, 7, 32'hFFFFFFFF); step();
        idle(); set_a(1'b0, 4'h0, 7, 32'h0); step();
        idle(); step();
        chk("be_merge", q_a0, 32'h11FF33FF);

        // Write-write collision on address 9.
        idle(); set_a(1'b1, 4'hF, 9, 32'h12); set_b(1'b1, 4'hF, 9, 32'h34); step();
        idle(); set_a(1'b0, 4'hF, 9, 32'h0); set_b(1'b0, 4'hF, 9, 32'h0); step();
        idle(); step();
        chk("coll A wins", q_a0, 32'h12);
        chk("coll B wins", q_b1, 32'h34);

        // Read-during-write, same and cross port.
        idle(); set_a(1'b1, 4'hF, 3, 32'h10); step();
        idle(); set_a(1'b1, 4'hF, 3, 32'h77); set_b(1'b0, 4'hF, 3, 32'h0); step();
        idle(); step();
        chk("rdw xport cfg0", q_b0, 32'h10);
        chk("rdw xport cfg1", q_b1, 32'h10);
        chk("rdw write-first", q_a0, 32'h77);
        chk("rdw read-first", q_a1, 32'h10);

        // Random traffic on a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rand_inputs(7);
            clr_req = ($urandom_range(0, 99) == 0);
            step();
        end
        wait_clear_done();

        // Load data, clear, hammer the ports while busy, reset mid-clear.
        for (int n = 0; n < 40; n++) begin
            rand_inputs(DEPTH - 1);
            we_a = 1'b1; we_b = 1'b1;
            step();
        end
        idle(); clr_req = 1'b1; step();
        for (int n = 0; n < 20; n++) begin
            rand_inputs(DEPTH - 1);
            clr_req = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        do_reset();
        for (int n = 0; n < 10; n++) begin
            rand_inputs(DEPTH - 1);
            step();
        end
        wait_clear_done();
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
